// File: rtl/xor_stream_unit.sv
// xor_stream_unit
//   Pipelined bitwise-logic stream stage. Each accepted beat is combined as
//   op(a,b) (XOR/XNOR/AND/OR, selectable per beat), registered once and
//   presented downstream under valid/ready. Per packet (closed by in_last) a
//   running XOR checksum and a saturating beat count are kept. A one-cycle
//   sum pulse reports them when the packet ends.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_in_valid / o_in_ready   input handshake
//   i_in_a, i_in_b [WIDTH]    operands
//   i_in_op [2]               00 XOR, 01 XNOR, 10 AND, 11 OR
//   i_in_last                 final beat of packet
//   o_out_valid / i_out_ready output handshake
//   o_out_data [WIDTH]        registered result
//   o_out_last                registered copy of in_last
//   o_sum_valid               one-cycle checksum pulse
//   o_sum_data [WIDTH]        XOR of all results of the packet
//   o_sum_count [CNT_W]       beats in the packet, saturating

// One bit-slice of the logic unit; replicated across the operand width.
module xsu_lane (
  input  logic [1:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_r
);
  always_comb begin
    o_r = 1'b0;
    case (i_op)
      2'b00:   o_r = i_a ^ i_b;
      2'b01:   o_r = ~(i_a ^ i_b);
      2'b10:   o_r = i_a & i_b;
      default: o_r = i_a | i_b;
    endcase
  end
endmodule

module xor_stream_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic [1:0]       i_in_op,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_last,
  output logic             o_sum_valid,
  output logic [WIDTH-1:0] o_sum_data,
  output logic [CNT_W-1:0] o_sum_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;
  } sum_t;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  logic             w_xfer;

  beat_t            r_out;
  logic             r_out_valid;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_sat;
  sum_t             r_sum, w_sum_nxt;
  logic             r_sum_valid, w_sum_valid_nxt;

  // Per-bit logic lanes
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    xsu_lane u_lane (
      .i_op (i_in_op),
      .i_a  (i_in_a[g]),
      .i_b  (i_in_b[g]),
      .o_r  (w_res[g])
    );
  end

  // Single register stage, no skid: accept only when the slot is free or
  // being drained this same edge.
  assign o_in_ready = !i_reset && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_xfer     = r_out_valid && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out.data  <= w_res;
      r_out.last  <= i_in_last;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out.data;
  assign o_out_last  = r_out.last;

  // Count sticks at all-ones instead of wrapping.
  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sum       <= w_sum_nxt;
      r_sum_valid <= w_sum_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_sum_nxt       = r_sum;
    w_sum_valid_nxt = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (i_in_last) begin
            // Single-beat packet: report directly, accumulator stays clear.
            w_sum_nxt.data  = w_res;
            w_sum_nxt.count = CNT_W'(1);
            w_sum_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ACTIVE;
            w_acc_nxt   = w_res;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        default: begin
          if (i_in_last) begin
            w_state_nxt     = S_IDLE;
            w_sum_nxt.data  = r_acc ^ w_res;
            w_sum_nxt.count = w_cnt_sat;
            w_sum_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
          end else begin
            w_acc_nxt = r_acc ^ w_res;
            w_cnt_nxt = w_cnt_sat;
          end
        end
      endcase
    end
  end

  assign o_sum_valid = r_sum_valid;
  assign o_sum_data  = r_sum.data;
  assign o_sum_count = r_sum.count;

endmodule

// File: tb/tb_xor_stream_unit.sv
module tb_xor_stream_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [1:0] in_op = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       rdy0, ov0, ol0, sv0;
  logic [7:0] od0, sd0, sc0;
  logic       rdy1, ov1, ol1, sv1;
  logic [7:0] od1, sd1;
  logic [1:0] sc1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xor_stream_unit #(.WIDTH(8), .CNT_W(8)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(rdy0),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_op(in_op), .i_in_last(in_last),
    .o_out_valid(ov0), .i_out_ready(out_ready), .o_out_data(od0),
    .o_out_last(ol0), .o_sum_valid(sv0), .o_sum_data(sd0), .o_sum_count(sc0)
  );

  xor_stream_unit #(.WIDTH(8), .CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(rdy1),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_op(in_op), .i_in_last(in_last),
    .o_out_valid(ov1), .i_out_ready(out_ready), .o_out_data(od1),
    .o_out_last(ol1), .o_sum_valid(sv1), .o_sum_data(sd1), .o_sum_count(sc1)
  );

  // Reference model: output slot plus the list of results of the open packet.
  logic       m_ov = 0, m_ol = 0, m_sv = 0;
  logic [7:0] m_od = 0, m_sd = 0, m_sc0 = 0;
  logic [1:0] m_sc1 = 0;
  logic [7:0] pkt[$];

  function automatic logic [7:0] opf(input logic [7:0] a, b, input logic [1:0] op);
    case (op)
      2'd0: return a ^ b;
      2'd1: return ~(a ^ b);
      2'd2: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic m_ready();
    return !reset && (!m_ov || out_ready);
  endfunction

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    logic acc;
    logic [7:0] r, x;
    acc = in_valid && m_ready();
    @(posedge clk);
    if (reset) begin
      m_ov = 0; m_od = 0; m_ol = 0; m_sv = 0; m_sd = 0; m_sc0 = 0; m_sc1 = 0;
      pkt.delete();
    end else begin
      m_sv = 0;
      if (acc) begin
        r = opf(in_a, in_b, in_op);
        pkt.push_back(r);
        m_od = r; m_ol = in_last; m_ov = 1;
        if (in_last) begin
          x = 0;
          foreach (pkt[i]) x ^= pkt[i];
          m_sd  = x;
          m_sc0 = (pkt.size() > 255) ? 8'd255 : 8'(pkt.size());
          m_sc1 = (pkt.size() > 3) ? 2'd3 : 2'(pkt.size());
          m_sv  = 1;
          pkt.delete();
        end
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic beat(input logic [7:0] a, b, input logic [1:0] op, input logic last);
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_last = last;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; out_ready = 1;
    tick(); tick();
    n_vec++;
    if ({ov0, od0, ol0, sv0, sd0, sc0} !== 34'h0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", {ov0, od0, ol0, sv0, sd0, sc0});
    end
    n_vec++;
    if ({rdy0, rdy1} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {rdy0, rdy1});
    end
    in_valid = 0; reset = 0; #1;
    n_vec++;
    if (rdy0 !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b want 1", rdy0);
    end
  endtask

  task automatic test_single();
    beat(8'hA5, 8'h0F, 2'd0, 1); tick(); in_valid = 0;
    n_vec++;
    if ({ov0, od0, ol0, sv0, sd0, sc0} !== {1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 8'd1}) begin
      n_err++; $display("FAIL single_beat: got %h want %h", {ov0, od0, ol0, sv0, sd0, sc0},
                        {1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 8'd1});
    end
    tick();
    n_vec++;
    if ({sv0, ov0} !== 2'b00) begin
      n_err++; $display("FAIL single_pulse_end: got sv/ov %b want 00", {sv0, ov0});
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_d[4];
    exp_d = '{8'hCC, 8'h33, 8'h30, 8'hFC};
    for (int i = 0; i < 4; i++) begin
      beat(8'hF0, 8'h3C, 2'(i), i == 3); tick();
      n_vec++;
      if ({od0, sv0} !== {exp_d[i], i == 3}) begin
        n_err++; $display("FAIL op_sweep[%0d]: got data %h sv %b want %h %b", i, od0, sv0, exp_d[i], i == 3);
      end
    end
    in_valid = 0;
    n_vec++;
    if ({sd0, sc0} !== {8'h33, 8'd4}) begin
      n_err++; $display("FAIL op_sweep_sum: got %h/%0d want 33/4", sd0, sc0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    beat(8'h01, 8'h00, 2'd0, 0); tick();
    beat(8'h02, 8'h00, 2'd0, 0); tick();
    n_vec++;
    if (sv0 !== 1'b0) begin
      n_err++; $display("FAIL b2b_no_early_sum: got %b want 0", sv0);
    end
    beat(8'h04, 8'h00, 2'd0, 1); tick();
    n_vec++;
    if ({sv0, sd0, sc0, ol0} !== {1'b1, 8'h07, 8'd3, 1'b1}) begin
      n_err++; $display("FAIL b2b_first: got sv %b sum %h cnt %0d last %b want 1 07 3 1", sv0, sd0, sc0, ol0);
    end
    beat(8'h80, 8'h00, 2'd0, 1); tick(); in_valid = 0;
    n_vec++;
    if ({sv0, sd0, sc0} !== {1'b1, 8'h80, 8'd1}) begin
      n_err++; $display("FAIL b2b_second: got sv %b sum %h cnt %0d want 1 80 1", sv0, sd0, sc0);
    end
    tick();
    n_vec++;
    if ({sv0, sd0} !== {1'b0, 8'h80}) begin
      n_err++; $display("FAIL b2b_hold: got sv %b sum %h want 0 80", sv0, sd0);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1;
    beat(8'h11, 8'h00, 2'd0, 0); tick();
    out_ready = 0;
    beat(8'h22, 8'h00, 2'd0, 1); #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (rdy0 !== 1'b0) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, rdy0);
      end
      tick();
      n_vec++;
      if ({ov0, od0, ol0} !== {1'b1, 8'h11, 1'b0}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got ov %b data %h last %b want 1 11 0", i, ov0, od0, ol0);
      end
    end
    out_ready = 1; #1;
    n_vec++;
    if (rdy0 !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 1", rdy0);
    end
    tick(); in_valid = 0;
    n_vec++;
    if ({ov0, od0, sv0, sd0, sc0} !== {1'b1, 8'h22, 1'b1, 8'h33, 8'd2}) begin
      n_err++; $display("FAIL bp_release: got ov %b data %h sv %b sum %h cnt %0d want 1 22 1 33 2",
                        ov0, od0, sv0, sd0, sc0);
    end
    tick();
    n_vec++;
    if (ov0 !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: got ov %b want 0", ov0);
    end
  endtask

  task automatic test_reset_mid();
    beat(8'h0A, 8'h00, 2'd0, 0); tick();
    beat(8'h0B, 8'h00, 2'd0, 0); out_ready = 0; tick();
    reset = 1; tick();
    n_vec++;
    if ({sv0, ov0, sd0, sc0} !== {1'b0, 1'b0, 8'h00, 8'd0}) begin
      n_err++; $display("FAIL reset_mid_clear: got sv %b ov %b sum %h cnt %0d want 0 0 00 0", sv0, ov0, sd0, sc0);
    end
    reset = 0; out_ready = 1;
    beat(8'h55, 8'h00, 2'd0, 1); tick(); in_valid = 0;
    n_vec++;
    if ({sv0, sd0, sc0, od0} !== {1'b1, 8'h55, 8'd1, 8'h55}) begin
      n_err++; $display("FAIL reset_mid_new: got sv %b sum %h cnt %0d data %h want 1 55 1 55", sv0, sd0, sc0, od0);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      beat(8'(i + 1), 8'h00, 2'd3, i == 4); tick();
    end
    in_valid = 0;
    n_vec++;
    if ({sv1, sc1, sc0, sd1} !== {1'b1, 2'd3, 8'd5, 8'h01}) begin
      n_err++; $display("FAIL sat_5beat: got sv %b cnt2 %0d cnt8 %0d sum %h want 1 3 5 01", sv1, sc1, sc0, sd1);
    end
    beat(8'h0F, 8'hF0, 2'd2, 0); tick();
    beat(8'h0F, 8'hF0, 2'd1, 1); tick(); in_valid = 0;
    n_vec++;
    if ({sv1, sc1, sd1} !== {1'b1, 2'd2, 8'h00}) begin
      n_err++; $display("FAIL sat_2beat: got sv %b cnt %0d sum %h want 1 2 00", sv1, sc1, sd1);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 2'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      #1;
      n_vec++;
      if ({rdy0, rdy1} !== {2{m_ready()}}) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, {rdy0, rdy1}, {2{m_ready()}});
      end
      tick();
      n_vec++;
      if ({ov0, od0, ol0, sv0, sd0, sc0} !== {m_ov, m_od, m_ol, m_sv, m_sd, m_sc0}) begin
        n_err++; $display("FAIL rnd_dut0[%0d]: got %h want %h", c, {ov0, od0, ol0, sv0, sd0, sc0},
                          {m_ov, m_od, m_ol, m_sv, m_sd, m_sc0});
      end
      n_vec++;
      if ({ov1, od1, ol1, sv1, sd1, sc1} !== {m_ov, m_od, m_ol, m_sv, m_sd, m_sc1}) begin
        n_err++; $display("FAIL rnd_dut1[%0d]: got %h want %h", c, {ov1, od1, ol1, sv1, sd1, sc1},
                          {m_ov, m_od, m_ol, m_sv, m_sd, m_sc1});
      end
    end
    reset = 0; in_valid = 0; out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_op_sweep();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
